// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

    // 2-bit saturating direction counter states
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = BP_WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / execute resolution bundle between the core and the branch predictor.
interface branch_predictor_if;
    // fetch lookup
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    // execute resolution
    logic        ex_valid;
    logic        ex_is_b_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_is_b_type, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_target,
        input  pred_valid, pred_taken, pred_hit, pred_target, ex_mispredict
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_is_b_type, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_target,
        output pred_valid, pred_taken, pred_hit, pred_target, ex_mispredict
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    // Step toward taken/not-taken, holding at the ends
    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            BP_SNT:  ctr_o = taken_i ? BP_WNT : BP_SNT;
            BP_WNT:  ctr_o = taken_i ? BP_WT  : BP_SNT;
            BP_WT:   ctr_o = taken_i ? BP_ST  : BP_WNT;
            BP_ST:   ctr_o = taken_i ? BP_ST  : BP_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter BHT plus direct-mapped BTB, trained at execute.
// Optional build macro BP_GSHARE_EN: XOR a global history register into the BHT index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned GHR_BITS    = 6
) (
    input  logic clk,
    input  logic rst_n,
    branch_predictor_if.slave bp
);

    localparam int unsigned BhtIdxW = $clog2(BHT_ENTRIES);
    localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW    = 32 - BtbIdxW - 2;

    bp_ctr_t           bht_q        [BHT_ENTRIES];
    logic              btb_valid_q  [BTB_ENTRIES];
    logic [TagW-1:0]   btb_tag_q    [BTB_ENTRIES];
    logic [31:0]       btb_target_q [BTB_ENTRIES];

    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic              pred_hit_q, pred_hit_d;
    logic [31:0]       pred_target_q, pred_target_d;

    logic [BhtIdxW-1:0] lk_bht_idx, up_bht_idx;
    logic [BtbIdxW-1:0] lk_btb_idx, up_btb_idx;
    logic [TagW-1:0]    lk_tag, up_tag;
    logic               upd;
    bp_ctr_t            ctr_next;
    logic               unused_pc_lsbs;

    assign upd        = bp.ex_valid & bp.ex_is_b_type;
    assign lk_btb_idx = bp.if_pc[BtbIdxW+1:2];
    assign up_btb_idx = bp.ex_pc[BtbIdxW+1:2];
    assign lk_tag     = bp.if_pc[31:BtbIdxW+2];
    assign up_tag     = bp.ex_pc[31:BtbIdxW+2];
    assign unused_pc_lsbs = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // Update indexes with the history before this branch is shifted in
    assign lk_bht_idx = bp.if_pc[BhtIdxW+1:2] ^ BhtIdxW'(ghr_q);
    assign up_bht_idx = bp.ex_pc[BhtIdxW+1:2] ^ BhtIdxW'(ghr_q);
    assign ghr_d      = upd ? {ghr_q[GHR_BITS-2:0], bp.ex_taken} : ghr_q;

    // Non-speculative global history, advanced only by resolved branches
    always_ff @(posedge clk) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    localparam int unsigned unused_ghr_bits = GHR_BITS;

    assign lk_bht_idx = bp.if_pc[BhtIdxW+1:2];
    assign up_bht_idx = bp.ex_pc[BhtIdxW+1:2];
`endif

    bp_sat_counter u_sat_counter (
        .ctr_i   (bht_q[up_bht_idx]),
        .taken_i (bp.ex_taken),
        .ctr_o   (ctr_next)
    );

    // Lookup reads table state before any same-cycle update (no bypass)
    always_comb begin
        pred_valid_d  = 1'b0;
        pred_taken_d  = 1'b0;
        pred_hit_d    = 1'b0;
        pred_target_d = '0;
        if (bp.if_valid) begin
            pred_valid_d = 1'b1;
            pred_hit_d   = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
            if (pred_hit_d) begin
                pred_target_d = btb_target_q[lk_btb_idx];
                pred_taken_d  = bht_q[lk_bht_idx][1];
            end
        end
    end

    // Prediction registers and table training
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BP_CTR_RESET;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_hit_q    <= pred_hit_d;
            pred_target_q <= pred_target_d;
            if (upd) bht_q[up_bht_idx] <= ctr_next;
            // Taken branches claim the BTB slot, evicting any alias
            if (upd && bp.ex_taken) begin
                btb_valid_q[up_btb_idx]  <= 1'b1;
                btb_tag_q[up_btb_idx]    <= up_tag;
                btb_target_q[up_btb_idx] <= bp.ex_target;
            end
        end
    end

    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_hit    = pred_hit_q;
    assign bp.pred_target = pred_target_q;

    // Redirect request; held low while in reset
    assign bp.ex_mispredict = rst_n & upd &
        ((bp.ex_taken != bp.ex_pred_taken) |
         (bp.ex_taken & (bp.ex_pred_target != bp.ex_target)));

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, BHT 64 / BTB 16).
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    branch_predictor_if bp_if ();

    branch_predictor #(
        .BHT_ENTRIES (64),
        .BTB_ENTRIES (16),
        .GHR_BITS    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp_if.if_valid       = 1'b0;
        bp_if.if_pc          = '0;
        bp_if.ex_valid       = 1'b0;
        bp_if.ex_is_b_type   = 1'b0;
        bp_if.ex_pc          = '0;
        bp_if.ex_target      = '0;
        bp_if.ex_taken       = 1'b0;
        bp_if.ex_pred_taken  = 1'b0;
        bp_if.ex_pred_target = '0;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bp_if.ex_valid       = 1'b1;
        bp_if.ex_is_b_type   = 1'b1;
        bp_if.ex_pc          = pc;
        bp_if.ex_target      = tgt;
        bp_if.ex_taken       = taken;
        bp_if.ex_pred_taken  = 1'b0;
        bp_if.ex_pred_target = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        set_resolve(pc, tgt, taken);
        tick();
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        bp_if.if_valid = 1'b1;
        bp_if.if_pc    = pc;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        chk("rst_pred_valid", 32'(bp_if.pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("rst_pred_hit", 32'(bp_if.pred_hit), 32'd0);
        chk("rst_pred_target", bp_if.pred_target, 32'h0);
        // Mispredicting resolve presented while in reset stays quiet
        set_resolve(32'h100, 32'h80, 1'b1);
        #1;
        chk("rst_no_mispredict", 32'(bp_if.ex_mispredict), 32'd0);
        idle();
        rst_n = 1'b1;

        // 1: cold lookup
        lookup(32'h100);
        chk("t1_valid", 32'(bp_if.pred_valid), 32'd1);
        chk("t1_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("t1_hit", 32'(bp_if.pred_hit), 32'd0);
        chk("t1_target", bp_if.pred_target, 32'h0);

        // idle cycle clears pred_valid
        tick();
        chk("idle_valid", 32'(bp_if.pred_valid), 32'd0);

        // 2: one taken resolve, predicted not-taken -> mispredict; then hit/taken
        set_resolve(32'h100, 32'h80, 1'b1);
        #1;
        chk("t2_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
        tick();
        idle();
        lookup(32'h100);
        chk("t2_hit", 32'(bp_if.pred_hit), 32'd1);
        chk("t2_target", bp_if.pred_target, 32'h80);
        chk("t2_taken", 32'(bp_if.pred_taken), 32'd1);

        // 3: saturate then decay
        do_reset();
        for (int i = 0; i < 4; i++) resolve(32'h200, 32'h240, 1'b1);
        resolve(32'h200, 32'h240, 1'b0);
        lookup(32'h200);
        chk("t3_taken_after_1nt", 32'(bp_if.pred_taken), 32'd1);
        resolve(32'h200, 32'h240, 1'b0);
        lookup(32'h200);
        chk("t3_taken_after_2nt", 32'(bp_if.pred_taken), 32'd0);
        chk("t3_hit_after_2nt", 32'(bp_if.pred_hit), 32'd1);
        chk("t3_target", bp_if.pred_target, 32'h240);

        // 4: BTB alias eviction (0x100 and 0x140 share BTB slot 0)
        do_reset();
        resolve(32'h100, 32'h80, 1'b1);
        resolve(32'h140, 32'hC0, 1'b1);
        lookup(32'h100);
        chk("t4_evicted_hit", 32'(bp_if.pred_hit), 32'd0);
        chk("t4_evicted_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("t4_evicted_target", bp_if.pred_target, 32'h0);
        lookup(32'h140);
        chk("t4_alias_hit", 32'(bp_if.pred_hit), 32'd1);
        chk("t4_alias_target", bp_if.pred_target, 32'hC0);
        chk("t4_alias_taken", 32'(bp_if.pred_taken), 32'd1);

        // 5: same-cycle update and lookup sees old counter
        do_reset();
        resolve(32'h100, 32'h80, 1'b1);
        resolve(32'h100, 32'h80, 1'b0);
        lookup(32'h100);
        chk("t5_pre_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("t5_pre_hit", 32'(bp_if.pred_hit), 32'd1);
        set_resolve(32'h100, 32'h80, 1'b1);
        bp_if.if_valid = 1'b1;
        bp_if.if_pc    = 32'h100;
        tick();
        idle();
        chk("t5_same_cycle_taken", 32'(bp_if.pred_taken), 32'd0);
        lookup(32'h100);
        chk("t5_next_taken", 32'(bp_if.pred_taken), 32'd1);

        // 6: target mispredict; non-branch and correct prediction stay low (no clock edge)
        bp_if.ex_valid       = 1'b1;
        bp_if.ex_is_b_type   = 1'b1;
        bp_if.ex_pc          = 32'h300;
        bp_if.ex_taken       = 1'b1;
        bp_if.ex_pred_taken  = 1'b1;
        bp_if.ex_pred_target = 32'h84;
        bp_if.ex_target      = 32'h80;
        #1;
        chk("t6_target_mispredict", 32'(bp_if.ex_mispredict), 32'd1);
        bp_if.ex_is_b_type = 1'b0;
        #1;
        chk("t6_non_branch", 32'(bp_if.ex_mispredict), 32'd0);
        bp_if.ex_is_b_type   = 1'b1;
        bp_if.ex_pred_target = 32'h80;
        #1;
        chk("t6_correct", 32'(bp_if.ex_mispredict), 32'd0);
        bp_if.ex_valid       = 1'b0;
        bp_if.ex_pred_target = 32'h84;
        #1;
        chk("t6_ex_invalid", 32'(bp_if.ex_mispredict), 32'd0);
        idle();

        // 7: mid-operation reset discards training
        resolve(32'h100, 32'h80, 1'b1);
        lookup(32'h100);
        chk("t7_trained_taken", 32'(bp_if.pred_taken), 32'd1);
        do_reset();
        lookup(32'h100);
        chk("t7_reset_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("t7_reset_hit", 32'(bp_if.pred_hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
